// File: rtl/flag_state_seq.sv
// Purpose: steps IDLE->RUN_A->RUN_B->DONE, gating each transition on the decoder's flag response.
// Latency: start to RUN_A is 1 cycle; nominal sequence 2*DWELL+1 cycles; outputs all registered.
// Backpressure: none; start is accepted only in IDLE and ignored elsewhere.
// Optional: define FLAG_CHECK_EN to flag illegal decoder codes (1/3) via a sticky err and abort.
module flag_state_seq #(
    parameter int DWELL     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] flag,
    output logic [1:0] curr_state,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN_A = 2'd1,
        S_RUN_B = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_M1  = 8'(DWELL - 1);
    localparam logic [4:0] MAX_R_EXT = 5'(MAX_RETRY);
    localparam logic [1:0] FLAG_GO   = 2'd2;

    state_t     state;
    logic [7:0] dcnt;
    logic [3:0] rcnt;
    logic       abort;
    logic       retry_ok;
    logic       in_run;
    logic       flag_bad;

    assign curr_state = state;
    assign in_run     = (state == S_RUN_A) || (state == S_RUN_B);

    // Extended by one bit so rcnt+1 cannot wrap before the compare.
    assign retry_ok = ({1'b0, rcnt} + 5'd1) < MAX_R_EXT;

`ifdef FLAG_CHECK_EN
    logic err_q;

    assign flag_bad = flag[0];
    assign err      = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err_q <= 1'b0;
        end else if (in_run && flag_bad) begin
            err_q <= 1'b1;
        end
    end
`else
    assign flag_bad = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            dcnt    <= 8'd0;
            rcnt    <= 4'd0;
            abort   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN_A;
                        busy  <= 1'b1;
                        dcnt  <= DWELL_M1;
                        rcnt  <= 4'd0;
                        abort <= 1'b0;
                    end
                end

                S_RUN_A: begin
                    if (flag_bad) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        abort   <= 1'b1;
                    end else if (dcnt != 8'd0) begin
                        dcnt <= dcnt - 8'd1;
                    end else if (flag == FLAG_GO) begin
                        state <= S_RUN_B;
                        dcnt  <= DWELL_M1;
                    end else if (retry_ok) begin
                        rcnt <= rcnt + 4'd1;
                        dcnt <= DWELL_M1;
                    end else begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        abort   <= 1'b1;
                    end
                end

                S_RUN_B: begin
                    if (flag_bad) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        abort   <= 1'b1;
                    end else if (dcnt != 8'd0) begin
                        dcnt <= dcnt - 8'd1;
                    end else begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b0;
                        abort   <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    timeout <= 1'b0;
                    abort   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/flag_state_seq.md
# flag_state_seq

Sequential driver for the 2-bit `curr_state` / `flag` interface. It steps a 2-bit state code through IDLE → RUN_A → RUN_B → DONE and presents that code on `curr_state` to the combinational flag decoder. It samples the decoder's `flag` response at the end of each dwell window, and that response gates each transition. The block sits upstream of the decoder and closes the loop that the decoder leaves open.

## Interface
- `DWELL`, default 4: cycles spent per attempt in RUN_A and per visit to RUN_B; legal range 1..255.
- `MAX_RETRY`, default 3: failed RUN_A attempts tolerated before abort; legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a sequence; sampled only in IDLE.
- `flag`  in  2  decoder response to `curr_state`.
- `curr_state`  out  2  registered state code: IDLE=0, RUN_A=1, RUN_B=2, DONE=3.
- `busy`  out  1  high whenever `curr_state` != 0.
- `done`  out  1  high exactly for the one cycle spent in DONE.
- `timeout`  out  1  high with `done` when the sequence aborted on retries.
- `err`  out  1  sticky illegal-flag indicator (see Configuration).

## Operation
- Internal registers:
  - 8-bit dwell counter `dcnt`.
  - 4-bit retry counter `rcnt`.
  - 1-bit abort marker.
- Reset (asynchronous, any time, including mid-sequence):
  - `curr_state`=0, `dcnt`=0, `rcnt`=0.
  - `busy`=0, `done`=0, `timeout`=0, `err`=0.
- IDLE:
  - `start`=1 → RUN_A, `dcnt`←DWELL-1, `rcnt`←0, `err`←0.
  - Otherwise stay.
- RUN_A:
  - If `dcnt`!=0, decrement and stay.
  - When `dcnt`==0, sample `flag`:
    - `flag`==2 → RUN_B, `dcnt`←DWELL-1.
    - `flag`!=2 and `rcnt`+1 < MAX_RETRY → stay in RUN_A, `rcnt`++, `dcnt`←DWELL-1.
    - `flag`!=2 and `rcnt`+1 == MAX_RETRY → DONE with the abort marker set.
- RUN_B:
  - Decrement `dcnt` each cycle.
  - When `dcnt`==0 → DONE, abort marker clear.
  - `flag` is ignored in RUN_B, except for the `err` check.
- DONE:
  - Lasts one cycle, then → IDLE unconditionally.
  - `start` during DONE is ignored.
- `start` asserted in any state other than IDLE has no effect.
- `timeout` = (state==DONE) & abort marker. `timeout` is never high without `done`.
- The retry counter compare uses width-extended arithmetic; no wrap is possible within the legal parameter range.

## Timing
- `start` high at edge k (in IDLE) → `curr_state`=1 from cycle k+1.
- Nominal path, no retries:
  - RUN_A for DWELL cycles, then RUN_B for DWELL cycles.
  - DONE for 1 cycle, IDLE again at k+2·DWELL+2.
- Each failed RUN_A attempt adds DWELL cycles.
- Abort path: `done`/`timeout` occur at k+MAX_RETRY·DWELL+1.
- `flag` is sampled in the same cycle that `curr_state` is presented. The decoder is combinational, so zero response latency is required.
- With DWELL=1, `dcnt` is 0 on entry, and every RUN_A/RUN_B cycle is an expiry cycle.
- Outputs are registered or pure decode of registered state; there are no combinational paths from `start` or `flag` to any output.

## Configuration
- Macro: `FLAG_CHECK_EN`.
- With `FLAG_CHECK_EN` defined:
  - `flag` value 1 or 3 observed in RUN_A or RUN_B sets `err`=1 (sticky until the next accepted `start` or `rst`).
  - The sequence is forced to DONE on the next edge with the abort marker set, so `timeout`=1.
- Without `FLAG_CHECK_EN`:
  - `err` is tied to 0.
  - Values 1 and 3 are treated as "not 2": a retry in RUN_A, ignored in RUN_B.

## Test plan
- Nominal path (DWELL=4, `flag`=2 whenever `curr_state`∈{0,1}):
  - Stimulus: `start` pulse at cycle 0.
  - Required: `curr_state`=1 in cycles 1–4, 2 in cycles 5–8, 3 in cycle 9 with `done`=1 and `timeout`=0, 0 in cycle 10.
- Retries then success (DWELL=4, MAX_RETRY=3):
  - Stimulus: `flag` held at 0 for the first RUN_A window, then 2.
  - Required: RUN_A spans cycles 1–8, RUN_B spans 9–12, `done` in cycle 13.
- Retry exhaustion (DWELL=4, MAX_RETRY=3):
  - Stimulus: `flag` held at 0 throughout.
  - Required: RUN_A spans cycles 1–12, cycle 13 has `done`=1 and `timeout`=1, never `curr_state`=2.
- Asynchronous reset mid-sequence:
  - Stimulus: `rst` asserted mid-cycle during RUN_B.
  - Required: all outputs 0 immediately, without waiting for an edge; `start` after release restarts the sequence from cycle 1.
- Start outside IDLE:
  - Stimulus: `start` held high continuously.
  - Required: back-to-back sequences separated by one IDLE cycle; a `start` pulse inside RUN_A alters no timing.
- Illegal flag, `FLAG_CHECK_EN` defined:
  - Stimulus: `flag`=3 in RUN_A cycle 2.
  - Required: `err`=1 from cycle 3; `done`=`timeout`=1 in cycle 3; `err` clears on the next accepted `start`.
- Illegal flag, `FLAG_CHECK_EN` undefined:
  - Stimulus: same as above.
  - Required: `err` stays 0 and the window counts as one retry.
